// File: rtl/tempsens_pkg.sv
// rtl/tempsens_pkg.sv - shared state encoding and defaults for the RO temperature sequencer
package tempsens_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_GATE    = 3'd2,
        S_HOLD    = 3'd3,
        S_CAPTURE = 3'd4,
        S_ACCUM   = 3'd5,
        S_COLLECT = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam int CW_DEF      = 16;
    localparam int TIMEOUT_DEF = 255;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tempsens_win_timer.sv
// rtl/tempsens_win_timer.sv - loadable down-counter; terminal count flags the last cycle of an interval
module tempsens_win_timer #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Loading len-1 makes o_tc high on exactly the len-th cycle after the load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/tempsens_seq.sv
// rtl/tempsens_seq.sv - RO temperature measurement sequencer; TEMPSENS_SEQ_TIMEOUT_EN adds the ACCUM wait timeout
module tempsens_seq
    import tempsens_pkg::*;
#(
    parameter int N          = 8,
    parameter int CW         = CW_DEF,
    parameter int WIN_W      = 12,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [CW-1:0]    i_ro_cnt,
    input  logic             i_avg_rdy,
    input  logic [N-1:0]     i_avg_out,
    output logic             o_ro_en,
    output logic             o_ro_cnt_clr,
    output logic             o_ro_cnt_gate,
    output logic             o_avg_en,
    output logic             o_avg_sum_en,
    output logic [CW-1:0]    o_avg_in,
    output logic [N-1:0]     o_result,
    output logic             o_result_valid,
    output logic             o_busy,
    output logic             o_ovf,
    output logic             o_err
);

    // One timer serves every interval, so it is sized for the widest of them.
    localparam int TW = max_int(WIN_W, max_int($clog2(SETTLE_CYC + 1), $clog2(TIMEOUT + 1)));

    state_t           r_state;
    state_t           w_next;
    logic [WIN_W-1:0] r_win;
    logic [CW-1:0]    r_avg_in;
    logic [N-1:0]     r_result;
    logic             r_ovf;

    logic             w_launch;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_tmr_tc;

    tempsens_win_timer #(
        .W(TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

`ifdef TEMPSENS_SEQ_TIMEOUT_EN
    logic r_err;
    logic w_set_err;
    logic w_clr_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_launch       = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_val      = '0;
        o_ro_en        = 1'b0;
        o_ro_cnt_clr   = 1'b0;
        o_ro_cnt_gate  = 1'b0;
        o_avg_en       = 1'b0;
        o_avg_sum_en   = 1'b0;
        o_result_valid = 1'b0;
`ifdef TEMPSENS_SEQ_TIMEOUT_EN
        w_set_err      = 1'b0;
        w_clr_err      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start || i_continuous) begin
                    w_next     = S_SETTLE;
                    w_launch   = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(SETTLE_CYC - 1);
`ifdef TEMPSENS_SEQ_TIMEOUT_EN
                    w_clr_err  = 1'b1;
`endif
                end
            end
            S_SETTLE: begin
                o_ro_en      = 1'b1;
                o_ro_cnt_clr = 1'b1;
                if (w_tmr_tc) begin
                    w_next     = S_GATE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(r_win) - TW'(1);
                end
            end
            S_GATE: begin
                o_ro_en       = 1'b1;
                o_ro_cnt_gate = 1'b1;
                if (w_tmr_tc) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                o_ro_en = 1'b1;
                w_next  = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_ro_en = 1'b1;
                w_next  = S_ACCUM;
`ifdef TEMPSENS_SEQ_TIMEOUT_EN
                w_tmr_load = 1'b1;
                w_tmr_val  = TW'(TIMEOUT - 1);
`endif
            end
            S_ACCUM: begin
                o_ro_en      = 1'b1;
                o_avg_en     = 1'b1;
                o_avg_sum_en = 1'b1;
                if (i_avg_rdy) begin
                    w_next = S_COLLECT;
`ifdef TEMPSENS_SEQ_TIMEOUT_EN
                end else if (w_tmr_tc) begin
                    w_next    = S_IDLE;
                    w_set_err = 1'b1;
`endif
                end
            end
            S_COLLECT: begin
                o_ro_en  = 1'b1;
                o_avg_en = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                o_ro_en        = 1'b1;
                o_result_valid = 1'b1;
                if (i_continuous) begin
                    w_next     = S_SETTLE;
                    w_launch   = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(SETTLE_CYC - 1);
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Window is frozen at launch; a zero request still gates for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_win <= '0;
        end else if (w_launch) begin
            r_win <= (i_win_len == '0) ? WIN_W'(1) : i_win_len;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_avg_in <= '0;
            r_ovf    <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_avg_in <= i_ro_cnt;
            r_ovf    <= (i_ro_cnt == {CW{1'b1}});
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_result <= '0;
        end else if (r_state == S_DONE) begin
            r_result <= i_avg_out;
        end
    end

`ifdef TEMPSENS_SEQ_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (w_clr_err) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_avg_in = r_avg_in;
    assign o_result = r_result;
    assign o_ovf    = r_ovf;
    assign o_busy   = (r_state != S_IDLE);

endmodule
